// File: rtl/instr_fetch_unit_if.sv
// -----------------------------------------------------------------------------
// instr_fetch_unit_if
// Bundles the instruction-memory read port, the execute-side redirect port and
// the decode-side valid/ready handshake of the instruction-fetch stage.
//
//   master : the fetch unit (drives imem_req/imem_addr and the held instruction)
//   slave  : instruction memory plus the decode/execute side
//
// Signals:
//   imem_req       fetch -> imem    read strobe
//   imem_addr      fetch -> imem    byte address of the read (the PC)
//   imem_rdata     imem  -> fetch   read data, valid the cycle after imem_req
//   redirect_valid exec  -> fetch   single-cycle PC-change pulse
//   redirect_pc    exec  -> fetch   redirect target byte address
//   instr_out      fetch -> decode  held instruction word
//   pc_out         fetch -> decode  PC of instr_out
//   pc_plus4_out   fetch -> decode  pc_out + 4 (mod 2^32)
//   instr_valid    fetch -> decode  instr_out/pc_out are valid
//   instr_ready    decode -> fetch  held instruction accepted this cycle
//   misaligned     fetch -> system  sticky misaligned-redirect flag
//   fetch_count    fetch -> system  completed handshakes (wraps)
// -----------------------------------------------------------------------------
interface instr_fetch_unit_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [31:0] instr_out;
    logic [31:0] pc_out;
    logic [31:0] pc_plus4_out;
    logic        instr_valid;
    logic        instr_ready;
    logic        misaligned;
    logic [31:0] fetch_count;

    modport master (
        output imem_req, imem_addr, instr_out, pc_out, pc_plus4_out,
               instr_valid, misaligned, fetch_count,
        input  imem_rdata, redirect_valid, redirect_pc, instr_ready
    );

    modport slave (
        input  imem_req, imem_addr, instr_out, pc_out, pc_plus4_out,
               instr_valid, misaligned, fetch_count,
        output imem_rdata, redirect_valid, redirect_pc, instr_ready
    );
endinterface

// File: rtl/instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// instr_fetch_unit
// Instruction-fetch stage: owns the PC, issues one word read per instruction to
// a one-cycle-latency instruction memory, holds the returned word and its PC in
// output registers and offers them downstream with a valid/ready handshake.
// Execute-side redirects replace the PC and drop any fetch in flight; a
// misaligned redirect target parks the unit in FAULT until reset.
//
// Ports:
//   clk    system clock, rising edge
//   reset  asynchronous, active-high reset
//   bus    instr_fetch_unit_if.master (imem port, redirect port, decode handshake)
// -----------------------------------------------------------------------------
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic                 clk,
    input  logic                 reset,
    instr_fetch_unit_if.master   bus
);

    typedef enum logic [1:0] {
        ST_ISSUE = 2'd0,
        ST_WAIT  = 2'd1,
        ST_HOLD  = 2'd2,
        ST_FAULT = 2'd3
    } state_t;

    state_t      r_state;
    logic [31:0] r_pc;
    logic [31:0] r_instr;
    logic [31:0] r_pc_out;
    logic        r_valid;
    logic        r_misaligned;
    logic [31:0] r_fetch_count;

    state_t      w_state_nxt;
    logic [31:0] w_pc_nxt;
    logic [31:0] w_instr_nxt;
    logic [31:0] w_pc_out_nxt;
    logic        w_valid_nxt;
    logic        w_misaligned_nxt;
    logic [31:0] w_fetch_count_nxt;
    logic        w_redirect;

    // FAULT is terminal, so a redirect there is simply not seen.
    assign w_redirect = bus.redirect_valid && (r_state != ST_FAULT);

    always_comb begin
        // NOTE: every variable gets a hold-value default before the case, so no
        // path leaves one unassigned and no latch is inferred.
        w_state_nxt       = r_state;
        w_pc_nxt          = r_pc;
        w_instr_nxt       = r_instr;
        w_pc_out_nxt      = r_pc_out;
        w_valid_nxt       = r_valid;
        w_misaligned_nxt  = r_misaligned;
        w_fetch_count_nxt = r_fetch_count;

        case (r_state)
            ST_ISSUE: w_state_nxt = ST_WAIT;
            ST_WAIT: begin
                w_instr_nxt  = bus.imem_rdata;
                w_pc_out_nxt = r_pc;
                w_valid_nxt  = 1'b1;
                w_pc_nxt     = r_pc + 32'd4;
                w_state_nxt  = ST_HOLD;
            end
            ST_HOLD: begin
                if (bus.instr_ready) begin
                    w_fetch_count_nxt = r_fetch_count + 32'd1;
                    w_valid_nxt       = 1'b0;
                    w_instr_nxt       = NOP_INSTR;
                    w_state_nxt       = ST_ISSUE;
                end
            end
            default: ; // ST_FAULT: hold everything
        endcase

        // Redirect overrides sequencing but keeps the fetch_count bump of a
        // handshake completing in the same HOLD cycle. Restoring pc/pc_out
        // undoes a WAIT-cycle capture so the in-flight word is dropped.
        if (w_redirect) begin
            w_valid_nxt  = 1'b0;
            w_instr_nxt  = NOP_INSTR;
            w_pc_out_nxt = r_pc_out;
            if (bus.redirect_pc[1:0] == 2'b00) begin
                w_pc_nxt    = bus.redirect_pc;
                w_state_nxt = ST_ISSUE;
            end else begin
                w_pc_nxt         = r_pc;
                w_misaligned_nxt = 1'b1;
                w_state_nxt      = ST_FAULT;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= ST_ISSUE;
            r_pc          <= RESET_PC;
            r_instr       <= NOP_INSTR;
            r_pc_out      <= RESET_PC;
            r_valid       <= 1'b0;
            r_misaligned  <= 1'b0;
            r_fetch_count <= 32'd0;
        end else begin
            r_state       <= w_state_nxt;
            r_pc          <= w_pc_nxt;
            r_instr       <= w_instr_nxt;
            r_pc_out      <= w_pc_out_nxt;
            r_valid       <= w_valid_nxt;
            r_misaligned  <= w_misaligned_nxt;
            r_fetch_count <= w_fetch_count_nxt;
        end
    end

    // Reset gates the strobe directly: the state already reads ISSUE while
    // reset is held, but no read may go out until it is released.
    assign bus.imem_req     = (r_state == ST_ISSUE) && !reset;
    assign bus.imem_addr    = r_pc;
    assign bus.instr_out    = r_instr;
    assign bus.pc_out       = r_pc_out;
    assign bus.pc_plus4_out = r_pc_out + 32'd4;
    assign bus.instr_valid  = r_valid;
    assign bus.misaligned   = r_misaligned;
    assign bus.fetch_count  = r_fetch_count;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_instr_fetch_unit
// Self-checking bench for instr_fetch_unit. Unit A (RESET_PC = 0) runs a
// cycle-by-cycle vector table; unit B (RESET_PC = 32'hFFFF_FFFC) covers PC
// wrap and reset during WAIT. A small synchronous memory model answers reads.
// -----------------------------------------------------------------------------
module tb_instr_fetch_unit;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic clk;
    logic reset_a;
    logic reset_b;

    instr_fetch_unit_if bus_a ();
    instr_fetch_unit_if bus_b ();

    instr_fetch_unit #(.RESET_PC(32'h0000_0000), .NOP_INSTR(NOP)) u_dut_a (
        .clk   (clk),
        .reset (reset_a),
        .bus   (bus_a.master)
    );

    instr_fetch_unit #(.RESET_PC(32'hFFFF_FFFC), .NOP_INSTR(NOP)) u_dut_b (
        .clk   (clk),
        .reset (reset_b),
        .bus   (bus_b.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction memory contents as a pure function of the address.
    function automatic logic [31:0] mem_word(input logic [31:0] addr);
        if (addr == 32'h0000_0000)      return 32'h0050_0093;
        else if (addr == 32'h0000_0004) return 32'h0000_0113;
        else                            return 32'hC0DE_0000 ^ addr;
    endfunction

    // One-cycle synchronous read latency.
    always @(posedge clk) begin
        if (bus_a.imem_req) bus_a.imem_rdata <= mem_word(bus_a.imem_addr);
        if (bus_b.imem_req) bus_b.imem_rdata <= mem_word(bus_b.imem_addr);
    end

    int n_checks = 0;
    int n_fails  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic        rdy;
        logic        rv;
        logic [31:0] rpc;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_valid;
        logic [31:0] e_instr;
        logic [31:0] e_pc;
        logic [31:0] e_cnt;
        logic        e_mis;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic rdy, input logic rv, input logic [31:0] rpc,
                       input logic e_req, input logic [31:0] e_addr,
                       input logic e_valid, input logic [31:0] e_pc,
                       input logic [31:0] e_cnt, input logic e_mis);
        vec_t v;
        v.rdy = rdy; v.rv = rv; v.rpc = rpc;
        v.e_req = e_req; v.e_addr = e_addr; v.e_valid = e_valid;
        v.e_pc = e_pc; v.e_cnt = e_cnt; v.e_mis = e_mis;
        v.e_instr = e_valid ? mem_word(e_pc) : NOP;
        vecs.push_back(v);
    endtask

    initial begin
        reset_a = 1'b1;
        reset_b = 1'b1;
        bus_a.redirect_valid = 1'b0; bus_a.redirect_pc = '0; bus_a.instr_ready = 1'b0;
        bus_b.redirect_valid = 1'b0; bus_b.redirect_pc = '0; bus_b.instr_ready = 1'b1;

        //   rdy rv  rpc            req addr          vld pc_out         cnt mis
        add(1, 0, 32'h0,          1, 32'h0000_0000, 0, 32'h0,         0, 0); // c0 ISSUE
        add(1, 0, 32'h0,          0, 32'h0,         0, 32'h0,         0, 0); // c1 WAIT
        add(1, 0, 32'h0,          0, 32'h0,         1, 32'h0000_0000, 0, 0); // c2 HOLD
        add(1, 0, 32'h0,          1, 32'h0000_0004, 0, 32'h0,         1, 0); // c3
        add(1, 0, 32'h0,          0, 32'h0,         0, 32'h0,         1, 0); // c4
        add(1, 0, 32'h0,          0, 32'h0,         1, 32'h0000_0004, 1, 0); // c5
        add(1, 0, 32'h0,          1, 32'h0000_0008, 0, 32'h0,         2, 0); // c6
        add(1, 0, 32'h0,          0, 32'h0,         0, 32'h0,         2, 0); // c7
        for (int i = 0; i < 5; i++)                                          // c8-c12 stall
            add(0, 0, 32'h0,      0, 32'h0,         1, 32'h0000_0008, 2, 0);
        add(1, 0, 32'h0,          0, 32'h0,         1, 32'h0000_0008, 2, 0); // c13 accept
        add(1, 0, 32'h0,          1, 32'h0000_000C, 0, 32'h0,         3, 0); // c14
        add(1, 1, 32'h0000_0100,  0, 32'h0,         0, 32'h0,         3, 0); // c15 WAIT redirect
        add(1, 0, 32'h0,          1, 32'h0000_0100, 0, 32'h0,         3, 0); // c16
        add(1, 0, 32'h0,          0, 32'h0,         0, 32'h0,         3, 0); // c17
        add(1, 1, 32'h0000_0200,  0, 32'h0,         1, 32'h0000_0100, 3, 0); // c18 HOLD redirect+ready
        add(1, 1, 32'h0000_0300,  1, 32'h0000_0200, 0, 32'h0,         4, 0); // c19 ISSUE redirect
        add(1, 0, 32'h0,          1, 32'h0000_0300, 0, 32'h0,         4, 0); // c20
        add(1, 0, 32'h0,          0, 32'h0,         0, 32'h0,         4, 0); // c21
        add(0, 0, 32'h0,          0, 32'h0,         1, 32'h0000_0300, 4, 0); // c22
        add(0, 1, 32'h0000_0102,  0, 32'h0,         1, 32'h0000_0300, 4, 0); // c23 misaligned
        for (int i = 0; i < 10; i++)                                         // c24-c33 FAULT
            add(1, (i == 2 || i == 6), 32'h0000_0400, 0, 32'h0, 0, 32'h0, 4, 1);

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("a_req_in_reset", {31'd0, bus_a.imem_req}, 32'd0);
        check("b_req_in_reset", {31'd0, bus_b.imem_req}, 32'd0);

        // Release just after a rising edge so the next falling edge is cycle 0.
        @(posedge clk);
        #2 reset_a = 1'b0;

        foreach (vecs[i]) begin
            @(negedge clk);
            bus_a.instr_ready    = vecs[i].rdy;
            bus_a.redirect_valid = vecs[i].rv;
            bus_a.redirect_pc    = vecs[i].rpc;
            #1;
            check($sformatf("c%0d_req", i),   {31'd0, bus_a.imem_req},    {31'd0, vecs[i].e_req});
            check($sformatf("c%0d_valid", i), {31'd0, bus_a.instr_valid}, {31'd0, vecs[i].e_valid});
            check($sformatf("c%0d_instr", i), bus_a.instr_out,            vecs[i].e_instr);
            check($sformatf("c%0d_cnt", i),   bus_a.fetch_count,          vecs[i].e_cnt);
            check($sformatf("c%0d_mis", i),   {31'd0, bus_a.misaligned},  {31'd0, vecs[i].e_mis});
            if (vecs[i].e_req)
                check($sformatf("c%0d_addr", i), bus_a.imem_addr, vecs[i].e_addr);
            if (vecs[i].e_valid) begin
                check($sformatf("c%0d_pc", i),    bus_a.pc_out,       vecs[i].e_pc);
                check($sformatf("c%0d_pc4", i),   bus_a.pc_plus4_out, vecs[i].e_pc + 32'd4);
            end
        end

        // Asynchronous reset while in FAULT: effect visible before any edge.
        @(negedge clk);
        bus_a.redirect_valid = 1'b0;
        #1 reset_a = 1'b1;
        #1;
        check("a_rst_mis",   {31'd0, bus_a.misaligned},  32'd0);
        check("a_rst_valid", {31'd0, bus_a.instr_valid}, 32'd0);
        check("a_rst_req",   {31'd0, bus_a.imem_req},    32'd0);
        check("a_rst_cnt",   bus_a.fetch_count,          32'd0);
        check("a_rst_instr", bus_a.instr_out,            NOP);
        check("a_rst_pc",    bus_a.pc_out,               32'h0);

        // Unit B: RESET_PC at the top of the address space.
        @(posedge clk);
        #2 reset_b = 1'b0;
        @(negedge clk); #1;                                   // c0 ISSUE
        check("b_c0_req",  {31'd0, bus_b.imem_req}, 32'd1);
        check("b_c0_addr", bus_b.imem_addr,         32'hFFFF_FFFC);
        @(negedge clk); #1;                                   // c1 WAIT
        check("b_c1_req",  {31'd0, bus_b.imem_req}, 32'd0);
        @(negedge clk); #1;                                   // c2 HOLD
        check("b_c2_valid", {31'd0, bus_b.instr_valid}, 32'd1);
        check("b_c2_pc",    bus_b.pc_out,               32'hFFFF_FFFC);
        check("b_c2_pc4",   bus_b.pc_plus4_out,         32'h0000_0000);
        check("b_c2_instr", bus_b.instr_out,            mem_word(32'hFFFF_FFFC));
        @(negedge clk); #1;                                   // c3 ISSUE, wrapped
        check("b_c3_req",  {31'd0, bus_b.imem_req}, 32'd1);
        check("b_c3_addr", bus_b.imem_addr,         32'h0000_0000);
        check("b_c3_cnt",  bus_b.fetch_count,       32'd1);
        @(negedge clk); #1;                                   // c4 WAIT: reset now
        reset_b = 1'b1;
        #1;
        check("b_rst_valid", {31'd0, bus_b.instr_valid}, 32'd0);
        check("b_rst_req",   {31'd0, bus_b.imem_req},    32'd0);
        check("b_rst_cnt",   bus_b.fetch_count,          32'd0);
        @(negedge clk); #1;                                   // edge passed in reset
        check("b_rst_valid2", {31'd0, bus_b.instr_valid}, 32'd0);
        check("b_rst_instr",  bus_b.instr_out,            NOP);
        check("b_rst_pc",     bus_b.pc_out,               32'hFFFF_FFFC);
        @(posedge clk);
        #2 reset_b = 1'b0;
        @(negedge clk); #1;
        check("b_rel_req",  {31'd0, bus_b.imem_req}, 32'd1);
        check("b_rel_addr", bus_b.imem_addr,         32'hFFFF_FFFC);
        @(negedge clk); #1;
        @(negedge clk); #1;
        check("b_rel_valid", {31'd0, bus_b.instr_valid}, 32'd1);
        check("b_rel_instr", bus_b.instr_out,            mem_word(32'hFFFF_FFFC));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
